mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the single 12-bit-address, 32-bit-data memory port between the command controller (port 0) and a secondary requester such as a readback or scrub engine (port 1). It sits between the requesters and the memory macro. It:
- accepts one request at a time with a valid/ready handshake;
- drives one memory access;
- returns a registered response pulse to the winning port.

Port 1 writes into a protected upper region are blocked and flagged.

## Interface
Parameters:
- PROT_BASE, 12'hF00, first protected address; port 1 writes at or above it are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid / req1_valid  input  1  request pending; addr/wdata/wen held stable until ready.
- req0_addr / req1_addr  input  12  word address.
- req0_wdata / req1_wdata  input  32  write data (ignored for reads).
- req0_wen / req1_wen  input  1  1 = write, 0 = read.
- req0_ready / req1_ready  output  1  accept strobe; request is taken at the edge where valid&ready.
- rsp0_valid / rsp1_valid  output  1  one-cycle response pulse.
- rsp0_rdata / rsp1_rdata  output  32  read data; 0 for writes and errors.
- rsp1_err  output  1  with rsp1_valid: protected write rejected.
- mem_addr  output  12  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid one cycle after mem_cen.
- mem_wen  output  1  write enable, meaningful only with mem_cen.
- mem_cen  output  1  active-high chip enable.
- arb_busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE → ACCESS on accept.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- IDLE:
  - ready is asserted combinationally for the winner only, while state is IDLE.
  - Winner is the only requester if just one valid.
  - If both are valid, winner is the port not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
  - On accept:
    - Register addr, wdata, wen and port id.
    - Update last_grant.
    - Evaluate err = (port==1) & wen & (addr >= PROT_BASE).
- ACCESS:
  - mem_cen=1 unless err.
  - mem_wen = registered wen & ~err.
  - mem_addr and mem_wdata come from registers.
  - Outside ACCESS, mem_cen, mem_wen, mem_addr and mem_wdata are 0.
- RESP:
  - Capture mem_rdata into the response register for reads without err; otherwise capture 0.
- Response:
  - At the edge leaving RESP, set rsp<port>_valid=1 for exactly one cycle, coincident with IDLE.
  - rsp1_err follows err during that cycle.
  - rspN_rdata holds its value until the next response to that port.
- No queueing. A non-winning requester keeps valid high and is served next; round-robin prevents starvation.
- A requester dropping valid before ready is legal; nothing is recorded.

## Timing
- Accept at edge of cycle T (IDLE, valid&ready).
- mem_cen high during T+1.
- mem_rdata sampled at the end of T+2.
- rsp_valid high during T+3.
- The cycle T+3 is also IDLE, so a new accept is possible there. Maximum throughput is one access per 3 cycles.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant=1.
  - Response registers 0.
- Reset asserted mid-operation: the access is abandoned, no response pulse is produced, and mem_cen drops asynchronously.
- Boundary behaviour:
  - addr 12'hFFF is legal.
  - A port 1 write at exactly PROT_BASE is rejected.
  - A port 1 read at PROT_BASE proceeds.
  - Port 0 writes are never rejected.

## Test plan
- Port 0 write addr 12'h010 data 32'hDEADBEEF, then read 12'h010 → mem_cen pulses at T+1 with mem_wen=1; the read's rsp0_valid comes 3 cycles after its accept with rsp0_rdata=32'hDEADBEEF.
- Both valid in the same cycle from reset → port 0 served first. Port 1 ready is asserted on the cycle rsp0_valid pulses, and rsp1_valid follows 3 cycles later.
- Both held valid for 6 accesses → grants alternate 0,1,0,1,0,1 with no port served twice in a row.
- Port 1 write 12'hF00 → mem_cen stays 0; rsp1_valid=1 with rsp1_err=1 and rsp1_rdata=0. Port 1 write 12'hEFF succeeds with err=0.
- rst_n low during ACCESS of a read → all outputs 0 immediately and no rsp pulse. After release, a port 1 request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response handshakes for both requester ports plus the shared memory port.
// slave = arbiter side, master = requesters and memory macro side.
interface mem_arbiter_if;
  logic        req0_valid;
  logic [11:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_wen;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;

  logic        req1_valid;
  logic [11:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_wen;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        rsp1_err;

  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic        mem_cen;

  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_wen,
    input  req1_valid, req1_addr, req1_wdata, req1_wen,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_addr, mem_wdata, mem_wen, mem_cen
  );

  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_wen,
    output req1_valid, req1_addr, req1_wdata, req1_wen,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_addr, mem_wdata, mem_wen, mem_cen
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single 12-bit address / 32-bit data memory port.
// One access per three cycles; port 1 writes at or above PROT_BASE are rejected with rsp1_err.
module mem_arbiter #(
  parameter logic [11:0] PROT_BASE = 12'hF00
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          arb_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_port;
  logic        r_wen;
  logic        r_err;
  logic        r_busy;
  logic        r_mem_cen;
  logic        r_mem_wen;
  logic [11:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic        r_rsp1_err;
  logic [31:0] r_rsp0_rdata;
  logic [31:0] r_rsp1_rdata;

  logic        w_idle;
  logic        w_win1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_wen;
  logic        w_err;
  logic [31:0] w_rsp_data;

  // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
  assign w_idle   = (r_state == IDLE);
  assign w_win1   = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_ready0 = w_idle & bus.req0_valid & ~w_win1;
  assign w_ready1 = w_idle & w_win1;
  assign w_accept = w_ready0 | w_ready1;

  assign w_addr  = w_win1 ? bus.req1_addr  : bus.req0_addr;
  assign w_wdata = w_win1 ? bus.req1_wdata : bus.req0_wdata;
  assign w_wen   = w_win1 ? bus.req1_wen   : bus.req0_wen;
  assign w_err   = w_win1 & w_wen & (w_addr >= PROT_BASE);

  assign w_rsp_data = (~r_wen & ~r_err) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_wen        <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_cen    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_err   <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= ACCESS;
            r_busy       <= 1'b1;
            r_port       <= w_win1;
            r_last_grant <= w_win1;
            r_wen        <= w_wen;
            r_err        <= w_err;
            // Memory strobes are loaded here so they are registered during ACCESS only.
            r_mem_cen    <= ~w_err;
            r_mem_wen    <= w_wen & ~w_err;
            r_mem_addr   <= w_addr;
            r_mem_wdata  <= w_wdata;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_mem_cen   <= 1'b0;
          r_mem_wen   <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (r_port) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_rdata <= w_rsp_data;
            r_rsp1_err   <= r_err;
          end else begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_rdata <= w_rsp_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp0_rdata = r_rsp0_rdata;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp1_rdata = r_rsp1_rdata;
  assign bus.rsp1_err   = r_rsp1_err;
  assign bus.mem_cen    = r_mem_cen;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign arb_busy       = r_busy;

endmodule
